// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcode encoding and legality helper
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_CMP = 4'd7
  } opcode_t;

  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO storage and pointers, no write-to-read bypass
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_q;
  // Head is read from storage only, so a word written this edge is never visible until the next.
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - command queue with opcode filter, registered ALU issue stage and drop counter
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic                   alu_stall,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OPCODE_W-1:0]    alu_opcode,
  output logic                   alu_issue,
  output logic                   drop_pulse,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int ENTRY_W = 2 * DATA_W + OPCODE_W;

  logic               accept, legal, fifo_push, fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;

  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OPCODE_W-1:0] alu_op_q, alu_op_d;
  logic                issue_q, issue_d;
  logic                drop_pulse_q, drop_pulse_d;
  logic [7:0]          drop_count_q, drop_count_d;

  // in_ready depends on registered occupancy only; a pop never frees a slot in the same cycle.
  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign legal     = is_legal_opcode(in_opcode);
  assign fifo_push = accept && legal;
  assign fifo_pop  = !alu_stall && !fifo_empty;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({in_a, in_b, in_opcode}),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    issue_d      = issue_q;
    drop_pulse_d = accept && !legal;
    drop_count_d = drop_count_q;
    if (!alu_stall) begin
      issue_d = fifo_pop;
      if (fifo_pop) {alu_a_d, alu_b_d, alu_op_d} = fifo_rdata;
    end
    if (drop_pulse_d && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      issue_q      <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      issue_q      <= issue_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign alu_issue  = issue_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  queue can accept a command this cycle.
REQ-006 in_a  input  8  operand A.
REQ-007 in_b  input  8  operand B.
REQ-008 in_opcode  input  4  ALU operation code.
REQ-009 alu_stall  input  1  downstream ALU stage holds the current issue.
REQ-010 alu_a  output  8  registered operand A to the ALU.
REQ-011 alu_b  output  8  registered operand B to the ALU.
REQ-012 alu_opcode  output  4  registered opcode to the ALU.
REQ-013 alu_issue  output  1  alu_a/alu_b/alu_opcode carry a new valid command this cycle.
REQ-014 drop_pulse  output  1  one-cycle pulse; an illegal-opcode command was discarded.
REQ-015 drop_count  output  8  saturating count of discarded commands.
REQ-016 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready at a rising edge.
REQ-018 in_ready SHALL equal (level != DEPTH), registered-state only, with no combinational path from alu_stall or in_valid.
REQ-019 Full FIFO with a pop in the same cycle SHALL still present in_ready=0; no same-cycle refill.
REQ-020 Legal opcodes SHALL be 0..7 (ADD, SUB, AND, OR, XOR, SHL, SHR, CMP); accepted legal commands SHALL be written at the tail.
REQ-021 Accepted opcodes 8..15 SHALL NOT be written; drop_pulse=1 for the following cycle; drop_count SHALL increment, saturating at 255.
REQ-022 Pop SHALL occur when alu_stall=0 and level>0: head loads alu_a/alu_b/alu_opcode; alu_issue=1 the next cycle.
REQ-023 alu_stall=0 and level=0: alu_issue SHALL be 0 next cycle; alu_a/alu_b/alu_opcode SHALL hold.
REQ-024 alu_stall=1: outputs and alu_issue SHALL hold; no pop.
REQ-025 No bypass: a command accepted at edge N SHALL pop no earlier than edge N+1; minimum accept-to-alu_issue latency SHALL be 2 cycles.
REQ-026 Simultaneous push and pop (not full) SHALL leave level unchanged and preserve order.
REQ-027 Commands SHALL issue strictly in acceptance order; pointers SHALL wrap modulo DEPTH.
REQ-028 Sustained in_valid=1, alu_stall=0 SHALL yield one issue per cycle after the initial latency.

Reset
REQ-029 At a rising edge with rst=1: level=0, pointers=0, alu_issue=0, alu_a=0, alu_b=0, alu_opcode=0, drop_pulse=0, drop_count=0; in_ready=1 the following cycle.
REQ-030 rst SHALL take priority over any simultaneous push, pop or stall; queued commands SHALL be discarded without issue.

Structure
REQ-031 Shared package alu_pkg SHALL hold DATA_W=8, OPCODE_W=4, opcode_t, the ADD..CMP opcode constants and an is_legal_opcode function; the ALU SHALL use the same package.
REQ-032 Storage and pointers SHALL be one sub-module, sync_fifo (parameterised width/depth, no bypass); legality filter, issue register and drop counter SHALL be in alu_issue_queue.

Verification
REQ-033 Reset then push {a=8'h05, b=8'h03, op=ADD}, alu_stall=0 -> alu_issue=1 exactly 2 cycles after accept with alu_a=05, alu_b=03, alu_opcode=0; level returns to 0.
REQ-034 alu_stall=1, push 4 commands (DEPTH=4) -> level=4, in_ready=0; a 5th in_valid is held; release stall -> 4 issues on consecutive cycles in order, then the 5th is accepted.
REQ-035 Push op=4'hA between two ADDs -> drop_pulse once, drop_count=1, only the two ADDs issue; 300 illegal pushes -> drop_count=255.
REQ-036 alu_stall=1 while alu_issue=1 for 3 cycles -> alu_a/alu_b/alu_opcode and alu_issue stable; next command issues only after stall drops.
REQ-037 rst=1 with level=3 and alu_issue=1 -> next cycle alu_issue=0, level=0, no queued command ever issues.
REQ-038 Random push/stall traffic for 10k cycles vs. a scoreboard -> order preserved, no loss, no duplication, level never exceeds DEPTH.
